// File: rtl/product_pkg.sv
// ---------------------------------------------------------------------------
// product_pkg
//   Shared types and helpers for the sequential signed multiplier
//   accumulator datapath.
//
//   op_t      : 2-bit opcode presented with op_valid.
//   state_t   : accumulator control states.
//   sext_width: width of the sign-extended upper-half add/subtract, one bit
//               wider than the half-width operands so the sum cannot
//               overflow.
// ---------------------------------------------------------------------------
package product_pkg;

  typedef enum logic [1:0] {
    OP_HOLD      = 2'b00,
    OP_LOAD      = 2'b01,
    OP_ADD_SHIFT = 2'b10,
    OP_SUB_SHIFT = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Adding two HALF-bit signed values needs HALF+1 bits to be exact.
  function automatic int sext_width(input int half);
    return half + 1;
  endfunction

endpackage

// File: rtl/product_addshift.sv
// ---------------------------------------------------------------------------
// product_addshift
//   Combinational add/subtract-and-shift step of the multiplier.
//   The upper half of the accumulator is sign-extended by one bit and has
//   the sign-extended partial product added (sub=0) or subtracted (sub=1).
//   The exact (HALF+1)-bit sum replaces the upper half and the whole
//   accumulator moves right by one, so the result is an arithmetic shift
//   right of (acc +/- pp * 2^HALF).
//
//   Ports
//     acc      in  WIDTH  current accumulator
//     pp       in  HALF   signed partial product
//     sub      in  1      1 = subtract pp, 0 = add pp
//     next_acc out WIDTH  accumulator after the step
// ---------------------------------------------------------------------------
module product_addshift
  import product_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [WIDTH/2-1:0] pp,
  input  logic               sub,
  output logic [WIDTH-1:0]   next_acc
);

  localparam int HALF = WIDTH / 2;
  localparam int SW   = sext_width(HALF);

  logic [SW-1:0] hi_ext;
  logic [SW-1:0] pp_ext;
  logic [SW-1:0] sum;
  logic          unused_lsb;

  // NOTE: every variable written in this block is assigned on every path,
  // so no latch can be inferred.
  always_comb begin
    hi_ext   = {acc[WIDTH-1], acc[WIDTH-1:HALF]};
    pp_ext   = {pp[HALF-1], pp};
    sum      = sub ? (hi_ext - pp_ext) : (hi_ext + pp_ext);
    // The full-width sum becomes the new upper bits; the old LSB falls off.
    next_acc = {sum, acc[HALF-1:1]};
  end

  // acc[0] is shifted out by construction.
  assign unused_lsb = acc[0];

endmodule

// File: rtl/product_acc_reg.sv
// ---------------------------------------------------------------------------
// product_acc_reg
//   Product accumulator register for the sequential signed multiplier.
//   A LOAD starts an operation; HALF add/sub-shift steps then build the
//   product, which is captured into a result register and offered to the
//   consumer with a valid/ready handshake. While a result is pending no
//   opcodes are accepted.
//
//   Ports
//     clk         in  1      clock, rising edge
//     rst         in  1      synchronous, active-high reset
//     op_valid    in  1      opcode present
//     op_ready    out 1      opcode accepted when op_valid && op_ready
//     op          in  2      HOLD / LOAD / ADD_SHIFT / SUB_SHIFT
//     in          in  WIDTH  LOAD value
//     pp          in  HALF   signed partial product for shift opcodes
//     acc         out WIDTH  live accumulator
//     prod        out WIDTH  last completed product
//     prod_valid  out 1      prod holds an unconsumed result
//     prod_ready  in  1      consumer accepts prod
//     err         out 1      sticky: shift issued with no operation running
// ---------------------------------------------------------------------------
module product_acc_reg
  import product_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   in,
  input  logic [WIDTH/2-1:0] pp,
  output logic [WIDTH-1:0]   acc,
  output logic [WIDTH-1:0]   prod,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic               err
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);

  // Counter value seen on the shift that completes the product.
  localparam logic [CW-1:0] LAST_STEP = CW'(HALF - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  op_t             op_code;
  logic            is_shift;
  logic            is_sub;
  logic [WIDTH-1:0] step_acc;

  assign op_code  = op_t'(op);
  assign is_shift = (op_code == OP_ADD_SHIFT) || (op_code == OP_SUB_SHIFT);
  assign is_sub   = (op_code == OP_SUB_SHIFT);

  // Ready depends on rst directly so nothing is accepted on a reset edge.
  assign op_ready = !rst && (state != ST_DONE);

  product_addshift #(
    .WIDTH (WIDTH)
  ) u_addshift (
    .acc      (acc),
    .pp       (pp),
    .sub      (is_sub),
    .next_acc (step_acc)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // in this block samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc        <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RUN: begin
          if (op_valid) begin
            if (op_code == OP_LOAD) begin
              // Also used to abort a running operation and restart.
              acc   <= in;
              cnt   <= '0;
              err   <= 1'b0;
              state <= ST_RUN;
            end else if (is_shift) begin
              if (state == ST_RUN) begin
                acc <= step_acc;
                if (cnt == LAST_STEP) begin
                  prod       <= step_acc;
                  prod_valid <= 1'b1;
                  cnt        <= '0;
                  state      <= ST_DONE;
                end else begin
                  cnt <= cnt + CW'(1);
                end
              end else begin
                // Shift with nothing loaded: flag it, touch nothing else.
                err <= 1'b1;
              end
            end
          end
        end

        ST_DONE: begin
          // Opcodes are refused here; only the result handshake advances.
          if (prod_valid && prod_ready) begin
            prod_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_acc_reg.sv
// ---------------------------------------------------------------------------
// tb_product_acc_reg
//   Self-checking bench for product_acc_reg (WIDTH=14). A behavioural model
//   treats the accumulator as a signed integer: each shift step computes
//   (acc +/- pp * 2^HALF) >>> 1, and completion is the HALF-th accepted
//   shift. A compare process checks every DUT output against the model on
//   each falling edge; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_product_acc_reg;

  localparam int W    = 14;
  localparam int H    = W / 2;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic         op_ready;
  logic [1:0]   op;
  logic [W-1:0] in_v;
  logic [H-1:0] pp;
  logic [W-1:0] acc;
  logic [W-1:0] prod;
  logic         prod_valid;
  logic         prod_ready;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  product_acc_reg #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op         (op),
    .in         (in_v),
    .pp         (pp),
    .acc        (acc),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_busy: an operation is loaded; m_pv: a result awaits the consumer.
  bit model_live = 1'b0;
  bit m_busy;
  int m_steps;
  int m_acc;
  int m_prod;
  bit m_pv;
  bit m_err;

  always @(posedge clk) begin
    if (rst) begin
      model_live = 1'b1;
      m_busy  = 1'b0;
      m_steps = 0;
      m_acc   = 0;
      m_prod  = 0;
      m_pv    = 1'b0;
      m_err   = 1'b0;
    end else if (model_live) begin
      if (m_pv) begin
        if (prod_ready) m_pv = 1'b0;
      end else if (op_valid) begin
        if (op == 2'b01) begin
          m_acc   = int'($signed(in_v));
          m_steps = 0;
          m_err   = 1'b0;
          m_busy  = 1'b1;
        end else if (op[1]) begin
          if (m_busy) begin
            if (op[0]) m_acc = (m_acc - int'($signed(pp)) * (1 << H)) >>> 1;
            else       m_acc = (m_acc + int'($signed(pp)) * (1 << H)) >>> 1;
            m_steps++;
            if (m_steps == H) begin
              m_prod  = m_acc;
              m_pv    = 1'b1;
              m_busy  = 1'b0;
              m_steps = 0;
            end
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("acc",        32'(acc),        32'(m_acc & MASK));
      check("prod",       32'(prod),       32'(m_prod & MASK));
      check("prod_valid", 32'(prod_valid), 32'(m_pv));
      check("err",        32'(err),        32'(m_err));
      check("op_ready",   32'(op_ready),   32'(!rst && !m_pv));
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 2 time units after a rising edge and are consumed on the
  // next rising edge.
  task automatic drive(input logic r, input logic v, input logic [1:0] o,
                       input logic [W-1:0] d, input logic [H-1:0] p,
                       input logic rdy);
    @(posedge clk);
    #2;
    rst        = r;
    op_valid   = v;
    op         = o;
    in_v       = d;
    pp         = p;
    prod_ready = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 1'b0, 2'b00, '0, '0, rdy);
  endtask

  task automatic add(input logic [H-1:0] p);
    drive(1'b0, 1'b1, 2'b10, '0, p, 1'b0);
  endtask

  task automatic load(input logic [W-1:0] d);
    drive(1'b0, 1'b1, 2'b01, d, '0, 1'b0);
  endtask

  initial begin
    logic       r;
    logic       v;
    logic       rdy;
    logic [1:0] o;
    int         sel;

    rst = 1'b1; op_valid = 1'b0; op = 2'b00; in_v = '0; pp = '0; prod_ready = 1'b0;

    // Reset, then idle.
    drive(1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
    drive(1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    check("rst_acc",      32'(acc),        32'h0);
    check("rst_prod",     32'(prod),       32'h0);
    check("rst_pv",       32'(prod_valid), 32'h0);
    check("rst_err",      32'(err),        32'h0);
    check("rst_op_ready", 32'(op_ready),   32'h1);

    // Positive add-shift, then backpressure.
    load(14'h0000);
    add(7'h01);
    add(7'h00);
    @(negedge clk);
    check("pos_acc1", 32'(acc), 32'h0040);
    repeat (5) add(7'h00);
    idle(1'b0);
    @(negedge clk);
    check("pos_pv",   32'(prod_valid), 32'h1);
    check("pos_prod", 32'(prod),       32'h0001);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 2'b01, 14'h2AAA, '0, 1'b0);
      @(negedge clk);
      check("bp_prod",     32'(prod),     32'h0001);
      check("bp_op_ready", 32'(op_ready), 32'h0);
      check("bp_acc",      32'(acc),      32'h0001);
    end
    idle(1'b1);
    idle(1'b0);
    @(negedge clk);
    check("bp_pv_fall",  32'(prod_valid), 32'h0);
    check("bp_ready_up", 32'(op_ready),   32'h1);
    check("bp_prod_hold", 32'(prod),      32'h0001);

    // Negative partial product, consumed on the first DONE cycle.
    load(14'h0000);
    add(7'h7F);
    add(7'h00);
    @(negedge clk);
    check("neg_acc1", 32'(acc), 32'h3FC0);
    repeat (5) add(7'h00);
    idle(1'b1);
    @(negedge clk);
    check("neg_pv",   32'(prod_valid), 32'h1);
    check("neg_prod", 32'(prod),       32'h3FFF);
    idle(1'b0);
    @(negedge clk);
    check("neg_consumed", 32'(prod_valid), 32'h0);
    check("neg_ready",    32'(op_ready),   32'h1);

    // Subtract-shift.
    load(14'h0000);
    drive(1'b0, 1'b1, 2'b11, '0, 7'h01, 1'b0);
    repeat (6) add(7'h00);
    idle(1'b1);
    @(negedge clk);
    check("sub_prod", 32'(prod), 32'h3FFF);
    idle(1'b0);

    // Error in IDLE, cleared by LOAD, then abort mid-run.
    drive(1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
    add(7'h05);
    idle(1'b0);
    @(negedge clk);
    check("err_set",      32'(err), 32'h1);
    check("err_acc_hold", 32'(acc), 32'h0);
    load(14'h1234);
    idle(1'b0);
    @(negedge clk);
    check("err_clear", 32'(err), 32'h0);
    check("load_acc",  32'(acc), 32'h1234);
    repeat (3) add(7'($urandom));
    load(14'h0000);
    repeat (6) add(7'($urandom));
    idle(1'b0);
    @(negedge clk);
    check("abort_six", 32'(prod_valid), 32'h0);
    add(7'h00);
    idle(1'b0);
    @(negedge clk);
    check("abort_seven", 32'(prod_valid), 32'h1);
    idle(1'b1);

    // Reset after three shifts.
    load(14'h0ABC);
    repeat (3) add(7'h15);
    drive(1'b1, 1'b1, 2'b10, '0, 7'h15, 1'b0);
    drive(1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
    @(negedge clk);
    check("mid_rst_acc", 32'(acc),        32'h0);
    check("mid_rst_pv",  32'(prod_valid), 32'h0);
    check("mid_rst_rdy", 32'(op_ready),   32'h0);
    idle(1'b0);

    // Randomised traffic against the model.
    repeat (3000) begin
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 9) != 0);
      sel = $urandom_range(0, 19);
      if (sel == 0)      o = 2'b00;
      else if (sel <= 2) o = 2'b01;
      else               o = {1'b1, 1'($urandom)};
      rdy = ($urandom_range(0, 3) != 0);
      drive(r, v, o, W'($urandom), H'($urandom), rdy);
    end
    idle(1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/product_acc_reg.md
# product_acc_reg

Parametrised product accumulator register for the sequential signed multiplier datapath. It replaces the plain enable register with:
- a WIDTH-bit accumulator driven by a load / add-shift / subtract-shift opcode;
- a step counter that detects when the product is complete;
- a completed-product output register with a valid/ready handshake.

It sits between the partial-product generator and the result consumer.

## Interface
- WIDTH, 14, product width; even, ≥4. HALF = WIDTH/2 is a derived localparam: multiplicand width and step count.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  opcode present this cycle
- op_ready  out  1  opcode accepted when op_valid && op_ready
- op  in  2  00 HOLD, 01 LOAD, 10 ADD_SHIFT, 11 SUB_SHIFT
- in  in  WIDTH  load value, used by LOAD
- pp  in  HALF  signed partial product, used by ADD/SUB_SHIFT
- acc  out  WIDTH  live accumulator
- prod  out  WIDTH  completed product
- prod_valid  out  1  prod holds an unconsumed result
- prod_ready  in  1  consumer accepts prod
- err  out  1  sticky: shift opcode issued with no operation in progress

## Operation
- States: IDLE, RUN, DONE. Counter cnt is $clog2(HALF+1) bits wide.
- op_ready = !rst && state != DONE. This is the only combinational output.
- HOLD: accepted in any ready state; no register changes.
- LOAD (IDLE or RUN):
  - acc <= in, cnt <= 0, err <= 0, state <= RUN.
  - LOAD in RUN aborts the current operation and restarts.
- ADD_SHIFT / SUB_SHIFT in RUN:
  - s = sext(acc[WIDTH-1:HALF], HALF+1) ± sext(pp, HALF+1), computed HALF+1 bits wide, so there is no overflow.
  - acc <= {s, acc[HALF-1:1]}, i.e. an arithmetic shift right by one.
  - cnt <= cnt+1.
- Completion: when the accepted shift op has cnt == HALF-1:
  - prod <= the new acc value; prod_valid <= 1; state <= DONE; cnt <= 0.
- ADD/SUB_SHIFT in IDLE: err <= 1; acc and cnt unchanged.
- DONE:
  - Ops are not accepted.
  - On prod_valid && prod_ready: prod_valid <= 0, state <= IDLE.
  - prod holds its value after consumption until the next completion.
- op_valid low: no state change, except the DONE handshake.

## Timing
- Reset values: acc=0, prod=0, prod_valid=0, err=0, cnt=0, state=IDLE. op_ready=0 while rst is high, and 1 in the first cycle after.
- rst mid-operation (RUN or DONE): all registers return to reset values on that edge, and any pending prod is discarded. rst wins over every op.
- Latency:
  - acc reflects an accepted op one cycle after acceptance.
  - prod_valid rises one cycle after the HALF-th shift is accepted.
  - Minimum operation time is 1 LOAD + HALF shifts + 1 handshake cycle.
- prod_ready held high in DONE: consumed on the first DONE cycle. op_ready returns to 1 on the following cycle.
- prod_ready low: prod and prod_valid are held indefinitely, and op_ready stays 0 (backpressure).
- A shift op with op_valid high while op_ready is 0 (DONE): ignored, with no err.

## Structure
- Package product_pkg:
  - op_t encodings: HOLD, LOAD, ADD_SHIFT, SUB_SHIFT.
  - state_t: IDLE, RUN, DONE.
  - Helper function for the sign-extend width.
- One sub-module, product_addshift: combinational, parametrised by WIDTH. Inputs acc, pp, sub; output next_acc. It is reused by the future radix-4 variant.
- The FSM, counter and output register stay in product_acc_reg.

## Test plan
All scenarios use WIDTH=14, HALF=7.
- **Reset:** reset, then idle → acc=0, prod=0, prod_valid=0, err=0, op_ready=1. Reset asserted after 3 shifts → all zero next cycle, no prod_valid.
- **Positive add-shift:** LOAD 14'h0000, ADD_SHIFT pp=7'h01, then 6× ADD_SHIFT pp=0 →
  - acc=14'h0040 after the first shift;
  - prod=14'h0001 and prod_valid=1 one cycle after the 7th shift.
- **Negative partial product:** LOAD 0, ADD_SHIFT pp=7'h7F, then 6× pp=0 →
  - acc=14'h3FC0 after the first shift;
  - prod=14'h3FFF.
- **Subtract-shift:** SUB_SHIFT pp=7'h01 first, then 6× ADD_SHIFT pp=0 → prod=14'h3FFF.
- **Backpressure:** prod_ready=0 for 5 cycles in DONE → prod stable, op_ready=0, and offered LOADs are ignored. Then prod_ready=1 → prod_valid falls and op_ready=1 on the next cycle.
- **Error and abort:**
  - ADD_SHIFT in IDLE → err=1, acc unchanged.
  - LOAD 14'h1234 → err=0, acc=14'h1234.
  - LOAD mid-RUN after 3 shifts → cnt restarts, and completion needs 7 further shifts.
